// File: rtl/cbus_master_if.sv
// Command/response and cbus AW/W/B/AR/R signal bundle for cbus_master.
// The master modport is the initiator view; slave is the controller/responder view.
interface cbus_master_if #(
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic [3:0]        cmd_wstrb;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_resp;

    logic [ADDR_W-1:0] cbus_awaddr;
    logic              cbus_awvalid;
    logic              cbus_awready;
    logic [31:0]       cbus_wdata;
    logic [3:0]        cbus_wstrb;
    logic              cbus_wvalid;
    logic              cbus_wready;
    logic [1:0]        cbus_bresp;
    logic              cbus_bvalid;
    logic              cbus_bready;
    logic [ADDR_W-1:0] cbus_araddr;
    logic              cbus_arvalid;
    logic              cbus_arready;
    logic [31:0]       cbus_rdata;
    logic [1:0]        cbus_rresp;
    logic              cbus_rvalid;
    logic              cbus_rready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
        output cbus_awaddr, cbus_awvalid, cbus_wdata, cbus_wstrb, cbus_wvalid,
        output cbus_bready, cbus_araddr, cbus_arvalid, cbus_rready,
        input  cbus_awready, cbus_wready, cbus_bresp, cbus_bvalid,
        input  cbus_arready, cbus_rdata, cbus_rresp, cbus_rvalid
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_resp,
        input  cbus_awaddr, cbus_awvalid, cbus_wdata, cbus_wstrb, cbus_wvalid,
        input  cbus_bready, cbus_araddr, cbus_arvalid, cbus_rready,
        output cbus_awready, cbus_wready, cbus_bresp, cbus_bvalid,
        output cbus_arready, cbus_rdata, cbus_rresp, cbus_rvalid
    );
endinterface

// File: rtl/cbus_master.sv
// Single-outstanding cbus initiator: command/response in, AW/W/B/AR/R out, all outputs registered.
// Optional per-state wait abort enabled by defining CBUS_MASTER_TIMEOUT_EN.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// WADDR | AW and W offered, each drops on its own handshake
// WRESP | bready high, waiting for B
// RADDR | AR offered
// RDATA | rready high, waiting for R
module cbus_master #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rstn,
    cbus_master_if.master bus
);
    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_e;

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_resp_q, rsp_resp_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic              awvalid_q, awvalid_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;

    logic accept, aw_done, w_done, ar_hs, b_hs, r_hs, timeout;

    assign accept  = bus.cmd_valid && cmd_ready_q;
    assign aw_done = !awvalid_q || bus.cbus_awready;
    assign w_done  = !wvalid_q || bus.cbus_wready;
    assign ar_hs   = arvalid_q && bus.cbus_arready;
    assign b_hs    = bready_q && bus.cbus_bvalid;
    assign r_hs    = rready_q && bus.cbus_rvalid;

`ifdef CBUS_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Down-counter reloaded on every state change; terminal count aborts the wait.
    assign timeout = (state_q != IDLE) && (tmo_q == '0);

    always_comb begin
        tmo_d = tmo_q;
        if (state_d != state_q) begin
            tmo_d = TMO_W'(TIMEOUT_CYCLES - 1);
        end else if (tmo_q != '0) begin
            tmo_d = tmo_q - TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_timeout_cycles;
    assign unused_timeout_cycles = (TIMEOUT_CYCLES != 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = bus.cmd_write ? WADDR : RADDR;
            WADDR:   if (aw_done && w_done) state_d = WRESP;
            WRESP:   if (b_hs) state_d = IDLE;
            RADDR:   if (ar_hs) state_d = RDATA;
            RDATA:   if (r_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

    // Output next-values derive from state_d so every output can be a flop.
    always_comb begin
        cmd_ready_d = (state_d == IDLE);
        bready_d    = (state_d == WRESP);
        arvalid_d   = (state_d == RADDR);
        rready_d    = (state_d == RDATA);

        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        if (state_q == IDLE) begin
            awvalid_d = accept && bus.cmd_write;
            wvalid_d  = accept && bus.cmd_write;
        end else if (state_q == WADDR && !timeout) begin
            awvalid_d = awvalid_q && !bus.cbus_awready;
            wvalid_d  = wvalid_q && !bus.cbus_wready;
        end

        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        araddr_d = araddr_q;
        if (accept && bus.cmd_write) begin
            awaddr_d = bus.cmd_addr;
            wdata_d  = bus.cmd_wdata;
            wstrb_d  = bus.cmd_wstrb;
        end
        if (accept && !bus.cmd_write) begin
            araddr_d = bus.cmd_addr;
        end

        rsp_valid_d = b_hs || r_hs || timeout;
        rsp_resp_d  = rsp_resp_q;
        rsp_rdata_d = rsp_rdata_q;
        if (timeout) begin
            rsp_resp_d  = 2'b10;
            rsp_rdata_d = '0;
        end else if (b_hs) begin
            rsp_resp_d  = bus.cbus_bresp;
            rsp_rdata_d = '0;
        end else if (r_hs) begin
            rsp_resp_d  = bus.cbus_rresp;
            rsp_rdata_d = bus.cbus_rdata;
        end
    end

    assign bus.cmd_ready    = cmd_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_resp     = rsp_resp_q;
    assign bus.cbus_awaddr  = awaddr_q;
    assign bus.cbus_awvalid = awvalid_q;
    assign bus.cbus_wdata   = wdata_q;
    assign bus.cbus_wstrb   = wstrb_q;
    assign bus.cbus_wvalid  = wvalid_q;
    assign bus.cbus_bready  = bready_q;
    assign bus.cbus_araddr  = araddr_q;
    assign bus.cbus_arvalid = arvalid_q;
    assign bus.cbus_rready  = rready_q;
endmodule

// File: tb/tb_cbus_master.sv
// Bench for cbus_master: table of transactions against a delay-programmable responder,
// scoreboard of expected responses, plus back-to-back, mid-transaction reset and timeout sequences.
`timescale 1ns/1ps
module tb_cbus_master;
    localparam int ADDR_W = 8;
    localparam int TMO    = 16;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    cbus_master_if #(.ADDR_W(ADDR_W)) bus ();

    cbus_master #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.master)
    );

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          a_dly;
        int          w_dly;
        int          x_dly;
        bit          silent;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    int          cfg_a_dly = 0, cfg_w_dly = 0, cfg_x_dly = 0;
    bit          cfg_silent = 1'b0;
    logic [1:0]  cfg_resp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          aw_n = 0, w_n = 0, ar_n = 0, b_wait = 0, r_wait = 0, b_hs = 0, r_hs = 0;
    logic [7:0]  act_addr = '0;
    logic [31:0] act_wdata = '0;
    logic [3:0]  act_wstrb = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Responder: decides ready/valid at negedge for the following rising edge.
    initial begin
        bus.cbus_awready = 1'b0;
        bus.cbus_wready  = 1'b0;
        bus.cbus_arready = 1'b0;
        bus.cbus_bvalid  = 1'b0;
        bus.cbus_bresp   = 2'b00;
        bus.cbus_rvalid  = 1'b0;
        bus.cbus_rresp   = 2'b00;
        bus.cbus_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                bus.cbus_awready = 1'b0;
                bus.cbus_wready  = 1'b0;
                bus.cbus_arready = 1'b0;
                bus.cbus_bvalid  = 1'b0;
                bus.cbus_rvalid  = 1'b0;
            end else begin
                bus.cbus_awready = bus.cbus_awvalid && !cfg_silent && (aw_n >= cfg_a_dly);
                if (bus.cbus_awvalid) aw_n++;
                bus.cbus_wready = bus.cbus_wvalid && !cfg_silent && (w_n >= cfg_w_dly);
                if (bus.cbus_wvalid) w_n++;
                bus.cbus_arready = bus.cbus_arvalid && !cfg_silent && (ar_n >= cfg_a_dly);
                if (bus.cbus_arvalid) ar_n++;
                bus.cbus_bvalid = bus.cbus_bready && !cfg_silent && (b_wait >= cfg_x_dly);
                bus.cbus_bresp  = bus.cbus_bvalid ? cfg_resp : 2'b00;
                if (bus.cbus_bready) b_wait++;
                if (bus.cbus_bvalid) b_hs++;
                bus.cbus_rvalid = bus.cbus_rready && !cfg_silent && (r_wait >= cfg_x_dly);
                bus.cbus_rresp  = bus.cbus_rvalid ? cfg_resp : 2'b00;
                bus.cbus_rdata  = bus.cbus_rvalid ? cfg_rdata : 32'h0;
                if (bus.cbus_rready) r_wait++;
                if (bus.cbus_rvalid) r_hs++;
            end
        end
    end

    // Monitor: channel stability, no read/write overlap, scoreboard compare on rsp_valid.
    always @(negedge clk) begin
        if (rstn) begin
            if (bus.cbus_awvalid) check("awaddr", 32'(bus.cbus_awaddr), 32'(act_addr));
            if (bus.cbus_wvalid) begin
                check("wdata", bus.cbus_wdata, act_wdata);
                check("wstrb", 32'(bus.cbus_wstrb), 32'(act_wstrb));
            end
            if (bus.cbus_arvalid) check("araddr", 32'(bus.cbus_araddr), 32'(act_addr));
            if (bus.cbus_awvalid || bus.cbus_wvalid || bus.cbus_bready ||
                bus.cbus_arvalid || bus.cbus_rready) begin
                check("channel_overlap",
                      32'((bus.cbus_awvalid || bus.cbus_wvalid || bus.cbus_bready) &&
                          (bus.cbus_arvalid || bus.cbus_rready)), 32'd0);
            end
            if (bus.rsp_valid) begin
                exp_t e;
                check("rsp_cmd_ready", 32'(bus.cmd_ready), 32'd1);
                check("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("rsp_resp", 32'(bus.rsp_resp), 32'(e.resp));
                    check("rsp_rdata", bus.rsp_rdata, e.rdata);
                    check("rsp_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic do_cmd(input vec_t v, input bit keep, output int c0);
        int n;
        n  = 0;
        c0 = -1;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = v.wr;
        bus.cmd_addr  = v.addr;
        bus.cmd_wdata = v.wdata;
        bus.cmd_wstrb = v.wstrb;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        if (bus.cmd_ready) begin
            c0 = cyc;
            @(posedge clk);
            #1;
            cfg_a_dly  = v.a_dly;
            cfg_w_dly  = v.w_dly;
            cfg_x_dly  = v.x_dly;
            cfg_silent = v.silent;
            cfg_resp   = v.resp;
            cfg_rdata  = v.rdata;
            act_addr   = v.addr;
            act_wdata  = v.wdata;
            act_wstrb  = v.wstrb;
            aw_n = 0; w_n = 0; ar_n = 0; b_wait = 0; r_wait = 0; b_hs = 0; r_hs = 0;
            sb_q.push_back('{resp: v.exp_resp, rdata: v.exp_rdata, cyc: c0 + v.exp_lat});
        end
        if (!keep || c0 < 0) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, " drain"}, 32'(sb_q.size() == 0), 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, " valids"}, 32'({bus.rsp_valid, bus.cbus_awvalid, bus.cbus_wvalid,
                                     bus.cbus_bready, bus.cbus_arvalid, bus.cbus_rready}), 32'd0);
        check({tag, " rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, " addr_resp"}, 32'({bus.rsp_resp, bus.cbus_wstrb, bus.cbus_awaddr,
                                        bus.cbus_araddr}), 32'd0);
        check({tag, " wdata"}, bus.cbus_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];

    initial begin
        vec_t v;
        int   c0a, c0b;

        vecs[0] = '{wr: 1'b1, addr: 8'h00, wdata: 32'h0000_1B20, wstrb: 4'hF, a_dly: 0, w_dly: 0,
                    x_dly: 0, silent: 1'b0, resp: 2'b00, rdata: 32'h0, exp_lat: 3,
                    exp_resp: 2'b00, exp_rdata: 32'h0};
        vecs[1] = '{wr: 1'b0, addr: 8'h02, wdata: 32'h0, wstrb: 4'h0, a_dly: 4, w_dly: 0,
                    x_dly: 0, silent: 1'b0, resp: 2'b00, rdata: 32'h0000_0055, exp_lat: 7,
                    exp_resp: 2'b00, exp_rdata: 32'h0000_0055};
        vecs[2] = '{wr: 1'b1, addr: 8'h10, wdata: 32'hDEAD_BEEF, wstrb: 4'h5, a_dly: 0, w_dly: 3,
                    x_dly: 1, silent: 1'b0, resp: 2'b01, rdata: 32'h0, exp_lat: 7,
                    exp_resp: 2'b01, exp_rdata: 32'h0};
        vecs[3] = '{wr: 1'b0, addr: 8'h7F, wdata: 32'h0, wstrb: 4'h0, a_dly: 0, w_dly: 0,
                    x_dly: 2, silent: 1'b0, resp: 2'b11, rdata: 32'hA5A5_0F0F, exp_lat: 5,
                    exp_resp: 2'b11, exp_rdata: 32'hA5A5_0F0F};
        vecs[4] = '{wr: 1'b1, addr: 8'hFF, wdata: 32'hFFFF_FFFF, wstrb: 4'h8, a_dly: 2, w_dly: 2,
                    x_dly: 0, silent: 1'b0, resp: 2'b10, rdata: 32'h1234_5678, exp_lat: 5,
                    exp_resp: 2'b10, exp_rdata: 32'h0};
        vecs[5] = '{wr: 1'b1, addr: 8'h3C, wdata: 32'h0BAD_F00D, wstrb: 4'h3, a_dly: 5, w_dly: 0,
                    x_dly: 0, silent: 1'b0, resp: 2'b00, rdata: 32'h0, exp_lat: 8,
                    exp_resp: 2'b00, exp_rdata: 32'h0};

        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_wstrb = '0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            do_cmd(v, 1'b0, c0a);
            wait_drain(60, $sformatf("vec%0d", i));
            if (v.wr) begin
                check($sformatf("vec%0d aw_cycles", i), 32'(aw_n), 32'(v.a_dly + 1));
                check($sformatf("vec%0d w_cycles", i), 32'(w_n), 32'(v.w_dly + 1));
                check($sformatf("vec%0d b_count", i), 32'(b_hs), 32'd1);
                check($sformatf("vec%0d ar_cycles", i), 32'(ar_n), 32'd0);
            end else begin
                check($sformatf("vec%0d ar_cycles", i), 32'(ar_n), 32'(v.a_dly + 1));
                check($sformatf("vec%0d r_count", i), 32'(r_hs), 32'd1);
                check($sformatf("vec%0d aw_cycles", i), 32'(aw_n), 32'd0);
            end
        end

        // Back-to-back: cmd_valid held, second command must land in the rsp_valid cycle.
        v = vecs[0];
        v.addr = 8'h20; v.wdata = 32'h0000_00C3;
        do_cmd(v, 1'b1, c0a);
        v = vecs[1];
        v.addr = 8'h21; v.a_dly = 0; v.exp_lat = 3; v.rdata = 32'h0000_0F0F; v.exp_rdata = 32'h0000_0F0F;
        do_cmd(v, 1'b0, c0b);
        check("b2b_accept_cycle", 32'(c0b), 32'(c0a + 3));
        wait_drain(40, "b2b");

        // Reset while waiting in WRESP: silent abort, registered outputs back to reset values.
        v = vecs[5];
        v.a_dly = 0; v.x_dly = 1000;
        do_cmd(v, 1'b0, c0a);
        for (int n = 0; n < 20 && !bus.cbus_bready; n++) @(negedge clk);
        check("reached_wresp", 32'(bus.cbus_bready), 32'd1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check_reset("mid_reset");
        sb_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cfg_x_dly = 0;
        repeat (6) @(negedge clk);
        check("post_reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("post_reset bready", 32'(bus.cbus_bready), 32'd0);

`ifdef CBUS_MASTER_TIMEOUT_EN
        v = vecs[1];
        v.addr = 8'h44; v.a_dly = 0; v.silent = 1'b1;
        v.exp_lat = TMO + 1; v.exp_resp = 2'b10; v.exp_rdata = 32'h0;
        do_cmd(v, 1'b0, c0a);
        wait_drain(TMO + 20, "timeout");
        check("timeout ar_cycles", 32'(ar_n), 32'(TMO));
        check("timeout r_count", 32'(r_hs), 32'd0);
        check("timeout arvalid_low", 32'(bus.cbus_arvalid), 32'd0);
`endif

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
